// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between
// the instruction-fetch and load/store requesters. One transaction in flight at a time.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fetch_req,
  input  logic [ADDR_WIDTH-1:0]   fetch_addr,
  output logic                    fetch_ack,
  output logic [DATA_WIDTH-1:0]   fetch_rdata,
  input  logic                    data_req,
  input  logic                    data_we,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  input  logic [DATA_WIDTH/8-1:0] data_wstrb,
  output logic                    data_ack,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  typedef enum logic {GRANT_FETCH, GRANT_DATA} grant_t;

  state_t               state;
  state_t               next_state;
  grant_t               last_grant;
  grant_t               winner;
  logic [CNT_WIDTH-1:0] lat_cnt;
  logic                 grant_fetch;
  logic                 grant_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Collisions go to the side that did not win last time, so neither starves.
  always_comb begin
    next_state  = state;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_req && data_req) begin
          if (last_grant == GRANT_FETCH) grant_data = 1'b1;
          else                           grant_fetch = 1'b1;
        end else if (fetch_req) begin
          grant_fetch = 1'b1;
        end else if (data_req) begin
          grant_data = 1'b1;
        end
        if (grant_fetch || grant_data) next_state = ACCESS;
      end
      ACCESS:  next_state = mem_we ? DONE : WAIT;
      WAIT:    if (lat_cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant  <= GRANT_FETCH;
      winner      <= GRANT_FETCH;
      lat_cnt     <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      fetch_ack   <= 1'b0;
      data_ack    <= 1'b0;
      fetch_rdata <= '0;
      data_rdata  <= '0;
    end else begin
      mem_en    <= 1'b0;
      fetch_ack <= 1'b0;
      data_ack  <= 1'b0;

      if (grant_fetch) begin
        mem_en     <= 1'b1;
        mem_we     <= 1'b0;
        mem_addr   <= fetch_addr;
        mem_wdata  <= '0;
        mem_wstrb  <= {STRB_WIDTH{1'b1}};
        winner     <= GRANT_FETCH;
        last_grant <= GRANT_FETCH;
      end else if (grant_data) begin
        mem_en     <= 1'b1;
        mem_we     <= data_we;
        mem_addr   <= data_addr;
        mem_wdata  <= data_wdata;
        mem_wstrb  <= data_we ? data_wstrb : {STRB_WIDTH{1'b1}};
        winner     <= GRANT_DATA;
        last_grant <= GRANT_DATA;
      end

      if (state == ACCESS) begin
        mem_we  <= 1'b0;
        lat_cnt <= CNT_WIDTH'(MEM_LATENCY - 1);
      end

      // Read data is captured exactly MEM_LATENCY cycles after the ACCESS cycle.
      if (state == WAIT) begin
        if (lat_cnt == '0) begin
          if (winner == GRANT_FETCH) fetch_rdata <= mem_rdata;
          else                       data_rdata  <= mem_rdata;
        end else begin
          lat_cnt <= lat_cnt - 1'b1;
        end
      end

      if (next_state == DONE) begin
        if (winner == GRANT_FETCH) fetch_ack <= 1'b1;
        else                       data_ack  <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LATENCY=1 and one
// at MEM_LATENCY=3, each with a small delay-line memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req, data_req, data_we;
  logic [31:0] fetch_addr, data_addr, data_wdata;
  logic [3:0]  data_wstrb;

  logic        fetch_ack, data_ack, mem_en, mem_we, busy;
  logic [31:0] fetch_rdata, data_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  logic        fetch_req3 = 1'b0;
  logic        data_req3;
  logic        fetch_ack3, data_ack3, mem_en3, mem_we3, busy3;
  logic [31:0] fetch_rdata3, data_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic [3:0]  mem_wstrb3;

  int check_count = 0;
  int pass_count  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_ack(data_ack), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req3), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack3), .fetch_rdata(fetch_rdata3),
    .data_req(data_req3), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_ack(data_ack3), .data_rdata(data_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_wstrb(mem_wstrb3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  function automatic logic [31:0] mem_value(input logic [31:0] addr);
    return (addr == 32'h100) ? 32'hDEADBEEF : (addr ^ 32'hA5A5_0000);
  endfunction

  // Memory models drive valid data only in the cycle MEM_LATENCY after mem_en.
  logic        en_d1 = 1'b0;
  logic [31:0] addr_d1 = '0;
  logic [2:0]  en_p3 = '0;
  logic [31:0] addr_p3 [3];

  always @(posedge clk) begin
    en_d1      <= mem_en;
    addr_d1    <= mem_addr;
    en_p3      <= {en_p3[1:0], mem_en3};
    addr_p3[0] <= mem_addr3;
    addr_p3[1] <= addr_p3[0];
    addr_p3[2] <= addr_p3[1];
  end

  assign mem_rdata  = en_d1    ? mem_value(addr_d1)    : 32'hBAD0BAD0;
  assign mem_rdata3 = en_p3[2] ? mem_value(addr_p3[2]) : 32'hBAD0BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic f_req, input logic [31:0] f_addr, input logic d_req,
                               input logic d_we, input logic [31:0] d_addr,
                               input logic [31:0] d_wdata, input logic [3:0] d_wstrb);
    fetch_req  = f_req;
    fetch_addr = f_addr;
    data_req   = d_req;
    data_we    = d_we;
    data_addr  = d_addr;
    data_wdata = d_wdata;
    data_wstrb = d_wstrb;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acks, last_cycle;
    logic [1:0] expected_side;
    data_req3 = 1'b0;
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h60, 32'h0, 4'h0);

    // Reset held two cycles with both requests high.
    reset = 1'b1;
    tick();
    tick();
    checkOutput("rst_mem_en",   32'(mem_en), 0);
    checkOutput("rst_mem_we",   32'(mem_we), 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_mem_wstrb", 32'(mem_wstrb), 0);
    checkOutput("rst_acks",     32'({fetch_ack, data_ack}), 0);
    checkOutput("rst_fetch_rdata", fetch_rdata, 0);
    checkOutput("rst_data_rdata",  data_rdata, 0);
    checkOutput("rst_busy",     32'(busy), 0);

    // First collision after reset goes to data.
    reset = 1'b0;
    tick();
    checkOutput("first_grant_en",   32'(mem_en), 1);
    checkOutput("first_grant_addr", mem_addr, 32'h60);
    checkOutput("first_grant_we",   32'(mem_we), 0);
    checkOutput("first_grant_strb", 32'(mem_wstrb), 32'hF);
    checkOutput("first_grant_busy", 32'(busy), 1);
    tick();
    tick();
    checkOutput("first_grant_acks",  32'({fetch_ack, data_ack}), 32'b01);
    checkOutput("first_grant_rdata", data_rdata, 32'hA5A50060);
    applyStimulus(1'b0, 32'h100, 1'b0, 1'b0, 32'h60, 32'h0, 4'h0);
    tick();
    checkOutput("first_grant_idle", 32'({busy, data_ack}), 0);

    // Store: ack two cycles after request, data_rdata untouched.
    applyStimulus(1'b0, 32'h100, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'b0011);
    tick();
    checkOutput("store_en",    32'(mem_en), 1);
    checkOutput("store_we",    32'(mem_we), 1);
    checkOutput("store_addr",  mem_addr, 32'h20);
    checkOutput("store_wdata", mem_wdata, 32'h12345678);
    checkOutput("store_wstrb", 32'(mem_wstrb), 32'b0011);
    tick();
    checkOutput("store_ack",   32'({fetch_ack, data_ack}), 32'b01);
    checkOutput("store_rdata", data_rdata, 32'hA5A50060);
    applyStimulus(1'b0, 32'h100, 1'b0, 1'b0, 32'h20, 32'h0, 4'h0);
    tick();
    checkOutput("store_after", 32'({busy, mem_en, mem_we, data_ack}), 0);

    // Single fetch at MEM_LATENCY=1.
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    checkOutput("fetch_en",   32'(mem_en), 1);
    checkOutput("fetch_addr", mem_addr, 32'h100);
    checkOutput("fetch_we",   32'(mem_we), 0);
    tick();
    checkOutput("fetch_ack_early", 32'(fetch_ack), 0);
    tick();
    checkOutput("fetch_ack",   32'({fetch_ack, data_ack}), 32'b10);
    checkOutput("fetch_rdata", fetch_rdata, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    checkOutput("fetch_after", 32'({busy, fetch_ack}), 0);

    // Continuous collision: last grant was fetch, so data, fetch, data, fetch.
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h60, 32'h0, 4'h0);
    acks = 0;
    last_cycle = 0;
    for (int cyc = 1; cyc <= 40 && acks < 4; cyc++) begin
      tick();
      if (fetch_ack || data_ack) begin
        expected_side = (acks % 2 == 0) ? 2'b01 : 2'b10;
        checkOutput($sformatf("collide_side_%0d", acks), 32'({fetch_ack, data_ack}), 32'(expected_side));
        if (data_ack) checkOutput($sformatf("collide_drdata_%0d", acks), data_rdata, 32'hA5A50060);
        else          checkOutput($sformatf("collide_frdata_%0d", acks), fetch_rdata, 32'hDEADBEEF);
        if (acks > 0) checkOutput($sformatf("collide_gap_%0d", acks), 32'(cyc - last_cycle), 4);
        last_cycle = cyc;
        acks++;
      end
    end
    checkOutput("collide_count", 32'(acks), 4);
    applyStimulus(1'b0, 32'h100, 1'b0, 1'b0, 32'h60, 32'h0, 4'h0);
    tick();
    checkOutput("collide_idle", 32'(busy), 0);

    // Reset during WAIT of a fetch drops it without an ack.
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    checkOutput("midwait_busy", 32'(busy), 1);
    reset = 1'b1;
    fetch_req = 1'b0;
    tick();
    checkOutput("midwait_rst", 32'({busy, mem_en, fetch_ack}), 0);
    checkOutput("midwait_rdata", fetch_rdata, 0);
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (fetch_ack) acks++;
    end
    checkOutput("midwait_no_ack", 32'(acks), 0);
    fetch_req = 1'b1;
    tick();
    checkOutput("reissue_en",   32'(mem_en), 1);
    checkOutput("reissue_addr", mem_addr, 32'h40);
    tick();
    tick();
    checkOutput("reissue_ack",   32'(fetch_ack), 1);
    checkOutput("reissue_rdata", fetch_rdata, 32'hA5A50040);
    fetch_req = 1'b0;
    tick();

    // MEM_LATENCY=3 load: ack in c+5.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h80, 32'h0, 4'h0);
    data_req3 = 1'b1;
    tick();
    checkOutput("lat3_en",    32'(mem_en3), 1);
    checkOutput("lat3_addr",  mem_addr3, 32'h80);
    checkOutput("lat3_we",    32'({mem_we3, mem_wstrb3}), 32'h0F);
    tick();
    tick();
    tick();
    checkOutput("lat3_ack_early", 32'(data_ack3), 0);
    tick();
    checkOutput("lat3_ack",   32'({fetch_ack3, data_ack3}), 32'b01);
    checkOutput("lat3_rdata", data_rdata3, 32'hA5A50080);
    checkOutput("lat3_frdata", fetch_rdata3, 0);
    data_req3 = 1'b0;
    tick();
    checkOutput("lat3_idle", 32'({busy3, data_ack3}), 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency memory between the instruction-fetch requester and the load/store requester of the 4-stage core (decode/setup/execute/writeback).
- Serialises requests, registers all memory-side outputs, collects read data after a fixed latency, and returns a one-cycle ack to the winning requester.
- Breaks fetch/data collisions round-robin so neither side starves.

Parameters:
- ADDR_WIDTH, 32: width of all address buses.
- DATA_WIDTH, 32: width of all data buses; must be a multiple of 8.
- MEM_LATENCY, 1: cycles from the mem_en cycle to the cycle mem_rdata is valid. Legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  fetch read request; held until fetch_ack
- fetch_addr  in  ADDR_WIDTH  fetch address; stable while fetch_req is high
- fetch_ack  out  1  one-cycle pulse; fetch_rdata is valid in this cycle
- fetch_rdata  out  DATA_WIDTH  fetch read data
- data_req  in  1  load/store request; held until data_ack
- data_we  in  1  1 = store, 0 = load
- data_addr  in  ADDR_WIDTH  load/store address
- data_wdata  in  DATA_WIDTH  store data
- data_wstrb  in  DATA_WIDTH/8  store byte enables
- data_ack  out  1  one-cycle completion pulse, for loads and stores
- data_rdata  out  DATA_WIDTH  load data; valid while data_ack is high
- mem_en  out  1  memory access strobe; high for exactly one cycle per transaction
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_wstrb  out  DATA_WIDTH/8  memory byte enables; all ones for reads
- mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after mem_en
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, active-high; clk) overrides everything: state=IDLE, last_grant=FETCH, all mem_* outputs 0, both acks 0, both rdata outputs 0, busy 0.
- A transaction in flight when reset asserts is dropped with no ack. Requesters reissue after reset.
- FSM states: IDLE, ACCESS, WAIT, DONE. Only one transaction is outstanding at a time.
- IDLE: sample fetch_req and data_req.
  - Only one high: grant it.
  - Both high: grant the side opposite last_grant, so the first collision after reset goes to data.
  - On grant: latch the winner id; load mem_we/mem_addr/mem_wdata/mem_wstrb from the winner (fetch: we=0, wstrb all ones); set mem_en=1; update last_grant; go to ACCESS.
  - Neither high: stay in IDLE.
- ACCESS: lasts one cycle with mem_en=1 (registered). At the end of the cycle mem_en and mem_we clear.
  - Store: go to DONE.
  - Load/fetch: load the latency counter with MEM_LATENCY-1 and go to WAIT.
- WAIT: count down. When the counter is 0, capture mem_rdata into the winner's rdata register and go to DONE.
  - This capture happens in the cycle exactly MEM_LATENCY after the ACCESS cycle.
- DONE: winner's ack=1 for exactly one cycle; the other ack stays 0; next state IDLE.
  - Requests are not sampled in DONE.
  - Requesters deassert req on the clock edge that consumes ack.
- Latency, counted from the first IDLE cycle in which req is seen (cycle c):
  - mem_en is high in c+1.
  - Store ack is in c+2.
  - Read ack is in c+2+MEM_LATENCY.
- Back-to-back: after DONE, IDLE re-arbitrates. Minimum spacing between mem_en pulses is 3 cycles for stores and 3+MEM_LATENCY for reads.
- fetch_rdata/data_rdata hold their last captured value until the next capture for the same side. A store never modifies data_rdata.
- The unselected requester's req may rise or fall while the arbiter is busy without effect; it is re-evaluated only in IDLE.
- Requests are never reordered and never lost while held: a held request is granted within one transaction of its first IDLE sample.

Test Plan:
- Reset: assert reset 2 cycles with both reqs high -> all outputs 0, busy 0; first grant after deassert goes to data.
- Single fetch, MEM_LATENCY=1: fetch_req in cycle c, fetch_addr=0x100, memory returns 0xDEADBEEF -> mem_en=1, mem_addr=0x100, mem_we=0 at c+1; fetch_ack=1, fetch_rdata=0xDEADBEEF at c+3.
- Store: data_we=1, addr=0x20, wdata=0x12345678, wstrb=4'b0011 -> mem_en=1, mem_we=1, mem_wstrb=0011 at c+1; data_ack at c+2; data_rdata unchanged.
- Collision: fetch_req and data_req held continuously for 4 transactions -> grant order data, fetch, data, fetch; each ack pulses exactly 1 cycle.
- Latency sweep: MEM_LATENCY=3 load -> data_ack at c+5, and data_rdata equals mem_rdata sampled 3 cycles after mem_en.
- Reset mid-WAIT: assert reset during WAIT of a fetch -> no fetch_ack ever; state IDLE; the reissued fetch completes normally.
